// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: one shift-add or
// restoring shift-subtract step per cycle. Owns the HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes land here
// RUN   | WIDTH iteration cycles, counter counts WIDTH-1 down to 0
// DONE  | sign fix-up, HI/LO written at the exit edge unless aborted
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hilo_rd,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;   // mul: product high half; div: partial remainder
  logic [WIDTH-1:0] ql;    // mul: multiplier / product low half; div: dividend / quotient
  logic [WIDTH-1:0] opnd;  // mul: multiplicand; div: divisor
  logic             is_div, neg_res, neg_rem, div0;
  logic             accept, commit;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, trial, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign a_neg = op[0] & src_a[WIDTH-1];
  assign b_neg = op[0] & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  assign mul_sum = {1'b0, acc} + (ql[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign trial   = {acc, ql[WIDTH-1]};
  assign diff    = trial - {1'b0, opnd};

  assign prod     = {acc, ql};
  assign prod_fix = neg_res ? -prod : prod;
  // Divide by zero leaves the restored dividend in acc, so HI comes back as src_a.
  assign q_fix    = div0 ? {WIDTH{1'b1}} : (neg_res ? -ql : ql);
  assign r_fix    = neg_rem ? -acc : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort)         state_nxt = IDLE;
        else if (cnt == 0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = ~abort;
        commit    = ~abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    stall = busy & (start | hilo_rd | wr_hi | wr_lo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      ql      <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      cnt     <= CW'(WIDTH - 1);
      acc     <= '0;
      is_div  <= op[1];
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      div0    <= (src_b == '0);
      if (op[1]) begin
        ql   <= a_mag;
        opnd <= b_mag;
      end else begin
        ql   <= b_mag;
        opnd <= a_mag;
      end
    end else if (state == IDLE) begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end else if (state == RUN) begin
      if (cnt != 0) cnt <= cnt - 1'b1;
      if (is_div) begin
        if (!diff[WIDTH]) begin
          acc <= diff[WIDTH-1:0];
          ql  <= {ql[WIDTH-2:0], 1'b1};
        end else begin
          acc <= trial[WIDTH-1:0];
          ql  <= {ql[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= mul_sum[WIDTH:1];
        ql  <= {mul_sum[0], ql[WIDTH-1:1]};
      end
    end else if (commit) begin
      if (is_div) begin
        hi <= r_fix;
        lo <= q_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized operations compared against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, hilo_rd, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .abort(abort), .hilo_rd(hilo_rd), .wr_hi(wr_hi),
    .wr_lo(wr_lo), .wr_data(wr_data), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Expected {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; hilo_rd = 0; wr_hi = 0; wr_lo = 0;
    op = 0; src_a = 0; src_b = 0; wr_data = 0;
  endtask

  // Issue one op in cycle 0, check done lands in cycle 33 and HI/LO in cycle 34.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] e;
    int cyc;
    e = model(o, a, b);
    op = o; src_a = a; src_b = b; start = 1;
    tick();
    start = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 33) begin
      errors++;
      $display("FAIL %s done_cycle got %0d exp 33", name, cyc);
    end
    tick();
    checks++;
    if (hi !== e[63:32] || lo !== e[31:0] || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0",
               name, hi, lo, busy, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    checks++;
    if (busy !== 0 || done !== 0 || stall !== 0 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b stall=%b hi=%h lo=%h exp all zero",
               busy, done, stall, hi, lo);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_directed();
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(2'd1, -32'sd3, 32'd7, "mult_neg");
    run_op(2'd3, -32'sd7, 32'd2, "div_neg");
    run_op(2'd2, 32'd100, 32'd0, "divu_by_zero");
    run_op(2'd3, 32'hFFFFFF9C, 32'd0, "div_by_zero_neg");
    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    run_op(2'd1, 32'h80000000, 32'h80000000, "mult_minmin");
    run_op(2'd3, 32'd7, -32'sd2, "div_neg_divisor");
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 50; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      run_op(o, a, b, "random");
    end
  endtask

  task automatic test_stall();
    logic [63:0] e1, e2;
    int cyc;
    e1 = model(2'd0, 32'h12345678, 32'h9ABCDEF0);
    e2 = model(2'd3, 32'hFFFF0000, 32'h00000123);
    op = 2'd0; src_a = 32'h12345678; src_b = 32'h9ABCDEF0; start = 1;
    tick();
    start = 0;
    tick();
    // cycle 2: a read, an MTHI and the next mul/div all wait for the unit
    hilo_rd = 1; wr_hi = 1; wr_data = 32'hDEADBEEF;
    op = 2'd3; src_a = 32'hFFFF0000; src_b = 32'h00000123; start = 1;
    for (int c = 2; c <= 33; c++) begin
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy cycle %0d got %b exp 1", c, stall);
      end
      tick();
    end
    #1;
    checks++;
    if (stall !== 0 || busy !== 0 || hi !== e1[63:32] || lo !== e1[31:0]) begin
      errors++;
      $display("FAIL stall_release got stall=%b busy=%b hi=%h lo=%h exp stall=0 busy=0 hi=%h lo=%h",
               stall, busy, hi, lo, e1[63:32], e1[31:0]);
    end
    tick();
    idle_inputs();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_start_accept got busy=%b exp 1", busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    tick();
    checks++;
    if (hi !== e2[63:32] || lo !== e2[31:0]) begin
      errors++;
      $display("FAIL held_start_result got hi=%h lo=%h exp hi=%h lo=%h",
               hi, lo, e2[63:32], e2[31:0]);
    end
  endtask

  task automatic test_abort();
    int ndone, cyc;
    wr_hi = 1; wr_data = 32'h11111111;
    tick();
    wr_hi = 0; wr_lo = 1; wr_data = 32'h22222222;
    tick();
    wr_lo = 0;
    checks++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      errors++;
      $display("FAIL preload got hi=%h lo=%h exp 11111111 22222222", hi, lo);
    end
    // abort in RUN cycle 10
    op = 2'd1; src_a = 32'h00001234; src_b = 32'hFFFF0001; start = 1;
    tick();
    start = 0;
    for (int i = 1; i < 10; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL abort_run_idle got busy=%b exp 0", busy);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      errors++;
      $display("FAIL abort_run_hilo got done_count=%0d hi=%h lo=%h exp 0 11111111 22222222",
               ndone, hi, lo);
    end
    // abort in DONE
    op = 2'd2; src_a = 32'd1000; src_b = 32'd7; start = 1;
    tick();
    start = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    abort = 1;
    #1;
    checks++;
    if (done !== 0 || cyc !== 33) begin
      errors++;
      $display("FAIL abort_done_flag got done=%b cycle=%0d exp done=0 cycle=33", done, cyc);
    end
    tick();
    abort = 0;
    tick();
    checks++;
    if (busy !== 0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      errors++;
      $display("FAIL abort_done_hilo got busy=%b hi=%h lo=%h exp 0 11111111 22222222",
               busy, hi, lo);
    end
    // MTHI in IDLE
    wr_hi = 1; wr_data = 32'hA5A5A5A5;
    tick();
    wr_hi = 0;
    checks++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'h22222222) begin
      errors++;
      $display("FAIL mthi got hi=%h lo=%h exp A5A5A5A5 22222222", hi, lo);
    end
    // abort in IDLE suppresses start
    op = 2'd0; src_a = 32'd3; src_b = 32'd4; start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL abort_idle_start got busy=%b exp 0", busy);
    end
    // start wins over MTLO in the same cycle
    start = 1; wr_lo = 1; wr_data = 32'h00000005;
    tick();
    start = 0; wr_lo = 0;
    checks++;
    if (busy !== 1 || lo !== 32'h22222222) begin
      errors++;
      $display("FAIL start_beats_mtlo got busy=%b lo=%h exp busy=1 lo=22222222", busy, lo);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL start_beats_mtlo_result got hi=%h lo=%h exp 00000000 0000000c", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    op = 2'd0; src_a = 32'hCAFEF00D; src_b = 32'h00000003; start = 1;
    tick();
    start = 0;
    for (int i = 1; i < 5; i++) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h exp all zero", busy, done, hi, lo);
    end
    run_op(2'd1, 32'hFFFFF000, 32'h00012345, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(2'd2, 32'hFFFFFFFF, 32'h00000010, "b2b_first");
    run_op(2'd0, 32'h0000FFFF, 32'h00010001, "b2b_second");
    run_op(2'd3, 32'h00000000, 32'hFFFFFFFF, "b2b_third");
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
